// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;
  localparam int REG_W        = 5;

endpackage

// File: rtl/muldiv_tracker.sv
// rtl/muldiv_tracker.sv - busy/done/error tracking for the multi-cycle mult/div unit in EX
module muldiv_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o,
  output logic error_o
);

  localparam int CW = $clog2(DIV_LAT + 1);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lat;
  logic          err_q, err_d;
  logic          last;

  assign lat  = is_div_i ? CW'(DIV_LAT) : CW'(MULT_LAT);
  assign last = (state_q == BUSY) && (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = lat;
        end
      end
      BUSY: begin
        // The final busy cycle accepts a new start so back-to-back ops have no gap
        if (last) begin
          state_d = start_i ? BUSY : IDLE;
          cnt_d   = start_i ? lat : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (start_i) err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_o  = ~rst_i & (state_q == BUSY);
  assign done_o  = ~rst_i & last;
  assign error_o = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / HI-LO stall, redirect flush and stall counter for IF/ID/EX
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_UsesHiLo,
  input  logic             ID_Redirect,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             EX_MulDivStart,
  input  logic             EX_IsDiv,
  output logic             PC_Enable,
  output logic             IFID_Enable,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MD_Busy,
  output logic             MD_Done,
  output logic             MD_Error,
  output logic [CNT_W-1:0] Stall_Count
);

  logic             lu, hl, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  muldiv_tracker #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (EX_MulDivStart),
    .is_div_i(EX_IsDiv),
    .busy_o  (MD_Busy),
    .done_o  (MD_Done),
    .error_o (MD_Error)
  );

  assign lu = EX_MemRead & (EX_Rt != '0) &
              ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
  // The HI/LO consumer may proceed in the done cycle: the result is forwarded then
  assign hl    = ID_UsesHiLo & MD_Busy & ~MD_Done;
  assign stall = lu | hl;

  // A redirect resolved on stale operands is dropped; it re-resolves after the stall
  assign PC_Enable   = ~RST & ~stall;
  assign IFID_Enable = ~RST & ~stall;
  assign IFID_Flush  = RST | (ID_Redirect & ~stall);
  assign IDEX_Flush  = RST | stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against a timeline model
module tb_pipe_hazard_ctrl;

  localparam int MLAT  = 4;
  localparam int DLAT  = 32;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          CLK;
  logic          RST;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
  logic          ID_UsesRt, ID_UsesHiLo, ID_Redirect;
  logic          EX_MemRead, EX_MulDivStart, EX_IsDiv;
  logic          PC_Enable, IFID_Enable, IFID_Flush, IDEX_Flush;
  logic          MD_Busy, MD_Done, MD_Error;
  logic [CW-1:0] Stall_Count;

  pipe_hazard_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_UsesHiLo(ID_UsesHiLo), .ID_Redirect(ID_Redirect),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_MulDivStart(EX_MulDivStart), .EX_IsDiv(EX_IsDiv),
    .PC_Enable(PC_Enable), .IFID_Enable(IFID_Enable),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_Error(MD_Error),
    .Stall_Count(Stall_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  wire [6:0] obs = {PC_Enable, IFID_Enable, IFID_Flush, IDEX_Flush, MD_Busy, MD_Done, MD_Error};

  int n_chk = 0;
  int n_fail = 0;

  // Timeline model: an op started at the edge closing cycle t is busy in cycles t+1 .. md_end
  int        cyc = 0;
  int        md_end = -1;
  int        m_cnt = 0;
  bit        md_err = 1'b0;
  bit        e_busy, e_done, e_stall;
  logic [6:0]    exp_v;
  logic [CW-1:0] exp_cnt;

  task automatic model_eval();
    bit lu, hl;
    e_busy  = !RST && (md_end >= cyc);
    e_done  = e_busy && (cyc == md_end);
    lu      = EX_MemRead && (EX_Rt != 0) &&
              ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
    hl      = ID_UsesHiLo && e_busy && !e_done;
    e_stall = !RST && (lu || hl);
    if (RST) exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, md_err};
    else     exp_v = {!e_stall, !e_stall, ID_Redirect && !e_stall, e_stall, e_busy, e_done, md_err};
    exp_cnt = CW'(m_cnt);
  endtask

  task automatic tick();
    model_eval();
    @(posedge CLK);
    if (RST) begin
      md_end = -1;
      md_err = 1'b0;
      m_cnt  = 0;
    end else begin
      if (e_stall && m_cnt < CMAX) m_cnt++;
      if (EX_MulDivStart) begin
        if (!e_busy || e_done) md_end = cyc + (EX_IsDiv ? DLAT : MLAT);
        else                   md_err = 1'b1;
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    ID_Rs = 0; ID_Rt = 0; EX_Rt = 0;
    ID_UsesRt = 0; ID_UsesHiLo = 0; ID_Redirect = 0;
    EX_MemRead = 0; EX_MulDivStart = 0; EX_IsDiv = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    EX_MulDivStart = 1;
    #1;
    n_chk++;
    if ({PC_Enable, IFID_Enable, IFID_Flush, IDEX_Flush, MD_Busy, MD_Done} !== 6'b001100) begin
      n_fail++;
      $display("FAIL reset_forced got=%b want=001100", {PC_Enable, IFID_Enable, IFID_Flush, IDEX_Flush, MD_Busy, MD_Done});
    end
    tick();
    #1; model_eval();
    n_chk++;
    if (obs !== exp_v || Stall_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL reset_hold got=%b/%0d want=%b/%0d", obs, Stall_Count, exp_v, exp_cnt);
    end
    tick();
    RST = 0;
    EX_MulDivStart = 0;
    #1; model_eval();
    n_chk++;
    if (obs !== exp_v || Stall_Count !== exp_cnt || obs !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_release got=%b/%0d want=%b/%0d", obs, Stall_Count, exp_v, exp_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] regs [3];
    regs[0] = 0; regs[1] = 8; regs[2] = 9;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      EX_MemRead = 1;
      EX_Rt      = (k == 1) ? 5'd0 : 5'd8;
      ID_Rs      = (k == 2) ? 5'd3 : EX_Rt;
      ID_Rt      = (k == 2) ? 5'd8 : 5'd0;
      #1; model_eval();
      n_chk++;
      if (obs !== exp_v || Stall_Count !== exp_cnt) begin
        n_fail++;
        $display("FAIL lu_directed%0d got=%b/%0d want=%b/%0d", k, obs, Stall_Count, exp_v, exp_cnt);
      end
      tick();
    end
    n_chk++;
    if (Stall_Count !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_count got=%0d want=1", Stall_Count);
    end
    for (int i = 0; i < 60; i++) begin
      clear_inputs();
      EX_MemRead = 1'($urandom);
      EX_Rt      = regs[$urandom_range(0, 2)];
      ID_Rs      = regs[$urandom_range(0, 2)];
      ID_Rt      = regs[$urandom_range(0, 2)];
      ID_UsesRt  = 1'($urandom);
      ID_Redirect = 1'($urandom);
      if (i % 15 == 0) RST = 1;
      #1; model_eval();
      n_chk++;
      if (obs !== exp_v || Stall_Count !== exp_cnt) begin
        n_fail++;
        $display("FAIL lu_random i=%0d got=%b/%0d want=%b/%0d", i, obs, Stall_Count, exp_v, exp_cnt);
      end
      tick();
      RST = 0;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ID_Redirect = 1;
    #1; model_eval();
    n_chk++;
    if (IFID_Flush !== 1'b1 || PC_Enable !== 1'b1 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL redirect_plain got=%b want=%b", obs, exp_v);
    end
    tick();
    EX_MemRead = 1; EX_Rt = 5'd12; ID_Rs = 5'd12;
    #1; model_eval();
    n_chk++;
    if (IFID_Flush !== 1'b0 || IDEX_Flush !== 1'b1 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL redirect_vs_stall got=%b want=%b", obs, exp_v);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mult_hilo();
    do_reset();
    EX_MulDivStart = 1;
    EX_IsDiv = 0;
    #1; model_eval();
    tick();
    EX_MulDivStart = 0;
    ID_UsesHiLo = 1;
    for (int i = 1; i <= 6; i++) begin
      #1; model_eval();
      n_chk++;
      if (obs !== exp_v || Stall_Count !== exp_cnt) begin
        n_fail++;
        $display("FAIL mult_hilo c%0d got=%b/%0d want=%b/%0d", i, obs, Stall_Count, exp_v, exp_cnt);
      end
      tick();
    end
    n_chk++;
    if (Stall_Count !== 4'd3) begin
      n_fail++;
      $display("FAIL mult_stalls got=%0d want=3", Stall_Count);
    end
    clear_inputs();
  endtask

  task automatic test_div_b2b_err();
    bit seen_done;
    do_reset();
    EX_MulDivStart = 1; EX_IsDiv = 1;
    tick();
    EX_MulDivStart = 0;
    for (int i = 0; i < DLAT + 4; i++) begin
      #1; model_eval();
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL div_run i=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (e_done) break;
      tick();
    end
    // new op issued on the done cycle
    EX_MulDivStart = 1; EX_IsDiv = 1;
    tick();
    EX_MulDivStart = 0;
    #1; model_eval();
    n_chk++;
    if (MD_Busy !== 1'b1 || MD_Error !== 1'b0 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL div_b2b got=%b want=%b", obs, exp_v);
    end
    for (int i = 0; i < DLAT + 4; i++) begin
      #1; model_eval();
      if (md_end - cyc + 1 == 10) break;
      tick();
    end
    EX_MulDivStart = 1; EX_IsDiv = 0;
    tick();
    EX_MulDivStart = 0;
    for (int i = 0; i < 14; i++) begin
      #1; model_eval();
      n_chk++;
      if (obs !== exp_v || (i == 8 && MD_Done !== 1'b1) || MD_Error !== 1'b1) begin
        n_fail++;
        $display("FAIL div_err i=%0d got=%b want=%b", i, obs, exp_v);
      end
      tick();
    end
    EX_MulDivStart = 1; EX_IsDiv = 1;
    tick();
    EX_MulDivStart = 0;
    for (int i = 0; i < 5; i++) tick();
    RST = 1;
    tick();
    tick();
    RST = 0;
    seen_done = 0;
    for (int i = 0; i < DLAT + 4; i++) begin
      #1; model_eval();
      if (MD_Done !== 1'b0) seen_done = 1;
      n_chk++;
      if (obs !== exp_v || MD_Error !== 1'b0) begin
        n_fail++;
        $display("FAIL div_abort i=%0d got=%b want=%b", i, obs, exp_v);
      end
      tick();
    end
    n_chk++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL div_abort_done got=1 want=0");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    EX_MemRead = 1; EX_Rt = 5'd8; ID_Rs = 5'd8;
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      #1; model_eval();
      n_chk++;
      if (obs !== exp_v || Stall_Count !== exp_cnt) begin
        n_fail++;
        $display("FAIL sat i=%0d got=%b/%0d want=%b/%0d", i, obs, Stall_Count, exp_v, exp_cnt);
      end
      tick();
    end
    n_chk++;
    if (Stall_Count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_final got=%0d want=15", Stall_Count);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      EX_Rt          = 5'($urandom_range(0, 3));
      ID_UsesRt      = 1'($urandom);
      ID_UsesHiLo    = 1'($urandom);
      ID_Redirect    = 1'($urandom);
      EX_MemRead     = ($urandom_range(0, 3) == 0);
      EX_MulDivStart = ($urandom_range(0, 7) == 0);
      EX_IsDiv       = ($urandom_range(0, 3) == 0);
      RST            = ($urandom_range(0, 59) == 0);
      #1; model_eval();
      n_chk++;
      if (obs !== exp_v || Stall_Count !== exp_cnt) begin
        n_fail++;
        $display("FAIL random i=%0d got=%b/%0d want=%b/%0d", i, obs, Stall_Count, exp_v, exp_cnt);
      end
      tick();
    end
    RST = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mult_hilo();
    test_div_b2b_err();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
